// File: rtl/mac_tbl_pkg.sv
// Shared types and constants for the MAC-table update path.
// Entry layout, flag encodings, requester indices and the sequencer states.
package mac_tbl_pkg;

    localparam int MAC_W     = 48;
    localparam int OUTPORT_W = 4;

    localparam logic FLAG_LOCAL   = 1'b0;
    localparam logic FLAG_UNLOCAL = 1'b1;

    localparam int REQ_INIT  = 0;
    localparam int REQ_LEARN = 1;
    localparam int REQ_CFG   = 2;

    typedef struct packed {
        logic [MAC_W-1:0]     mac;
        logic [OUTPORT_W-1:0] outport;
        logic                 flag;
    } entry_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N. Produces one-hot grant, its index, and an any flag.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Offset i from ptr is visited in order; j is the candidate that sits at that offset.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!any && req[j] && (j == ((int'(ptr) + i) % N))) begin
                    any      = 1'b1;
                    grant[j] = 1'b1;
                    idx      = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mac_update_arbiter.sv
// Shares the single MAC-table update port between the init, learning and config
// requesters: INIT phase serves req0 only, RUN phase round-robins all of them.
module mac_update_arbiter
    import mac_tbl_pkg::*;
#(
    parameter  int P_OUTPORT_WIDTH = 4,
    parameter  int P_REQ_NUM       = 3,
    parameter  int P_INIT_ENTRIES  = 16,
    localparam int IW              = $clog2(P_REQ_NUM)
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic [P_REQ_NUM-1:0]                 i_req_valid,
    output logic [P_REQ_NUM-1:0]                 o_req_ready,
    input  logic [48*P_REQ_NUM-1:0]              i_req_dest_mac,
    input  logic [P_OUTPORT_WIDTH*P_REQ_NUM-1:0] i_req_outport,
    input  logic [P_REQ_NUM-1:0]                 i_req_flag,
    output logic [47:0]                          o_update_dest_mac,
    output logic [P_OUTPORT_WIDTH-1:0]           o_update_outport,
    output logic                                 o_update_flag,
    output logic                                 o_update_valid,
    input  logic                                 i_update_ready,
    output logic [IW-1:0]                        o_grant_id,
    output logic                                 o_init_done,
    output state_t                               o_state
);

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both
    // high; valid and payload never change while valid is high and ready is low.
    // Requester ready depends combinationally on i_update_ready, never the reverse.

    logic                 slot_free;
    logic                 accept;
    logic                 out_hs;
    logic                 init_hs;
    logic                 any;
    logic [P_REQ_NUM-1:0] elig;
    logic [P_REQ_NUM-1:0] grant;
    logic [IW-1:0]        gidx;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        ptr_nxt;
    logic [7:0]           init_cnt;

    assign slot_free = !o_update_valid || i_update_ready;
    assign elig      = (o_state == ST_INIT) ? (i_req_valid & P_REQ_NUM'(1)) : i_req_valid;

    rr_arbiter #(.N(P_REQ_NUM)) u_rr (
        .req   (elig),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (any)
    );

    // Reset gates ready so nothing is accepted while the table is held in reset.
    assign accept      = any && slot_free && i_rst_n;
    assign o_req_ready = accept ? grant : '0;
    assign out_hs      = o_update_valid && i_update_ready;
    assign init_hs     = (o_state == ST_INIT) && out_hs && (o_grant_id == '0);
    assign ptr_nxt     = (gidx == IW'(P_REQ_NUM - 1)) ? '0 : gidx + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_state           <= ST_INIT;
            o_update_valid    <= 1'b0;
            o_update_dest_mac <= '0;
            o_update_outport  <= '0;
            o_update_flag     <= 1'b0;
            o_grant_id        <= '0;
            o_init_done       <= 1'b0;
            ptr               <= '0;
            init_cnt          <= '0;
        end else begin
            if (accept) begin
                o_update_valid    <= 1'b1;
                o_update_dest_mac <= i_req_dest_mac[int'(gidx)*48 +: 48];
                o_update_outport  <= i_req_outport[int'(gidx)*P_OUTPORT_WIDTH +: P_OUTPORT_WIDTH];
                o_update_flag     <= i_req_flag[gidx];
                o_grant_id        <= gidx;
            end else if (i_update_ready) begin
                o_update_valid <= 1'b0;
            end

            case (o_state)
                ST_INIT: begin
                    if (init_hs) begin
                        if (init_cnt == 8'(P_INIT_ENTRIES - 1)) begin
                            init_cnt    <= 8'(P_INIT_ENTRIES);
                            o_state     <= ST_RUN;
                            o_init_done <= 1'b1;
                        end else begin
                            init_cnt <= init_cnt + 8'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        ptr <= ptr_nxt;
                    end
                end
                default: o_state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_update_arbiter.sv
// Scoreboard bench for mac_update_arbiter: per-requester source queues feed the DUT,
// expected entries (id + payload) are queued in grant order and popped on output.
module tb_mac_update_arbiter;
    import mac_tbl_pkg::*;

    localparam int NREQ  = 3;
    localparam int OW    = 4;
    localparam int IW    = 2;
    localparam int NINIT = 16;
    localparam int EW    = IW + $bits(entry_t);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      i_req_valid;
    logic [NREQ-1:0]      o_req_ready;
    logic [48*NREQ-1:0]   i_req_dest_mac;
    logic [OW*NREQ-1:0]   i_req_outport;
    logic [NREQ-1:0]      i_req_flag;
    logic [47:0]          o_update_dest_mac;
    logic [OW-1:0]        o_update_outport;
    logic                 o_update_flag;
    logic                 o_update_valid;
    logic                 i_update_ready;
    logic [IW-1:0]        o_grant_id;
    logic                 o_init_done;
    state_t               o_state;
    logic [EW-1:0]        out_word;

    entry_t               src_q[NREQ][$];
    logic [EW-1:0]        exp_q[$];
    int                   n_cmp = 0;
    int                   n_err = 0;
    int                   tb_init_cnt;
    logic                 tb_init_done;
    logic                 upd_ready;
    logic [NREQ-1:0]      last_ready;
    logic                 prev_stall;
    logic [EW-1:0]        prev_out;

    always #5 clk = ~clk;

    mac_update_arbiter #(
        .P_OUTPORT_WIDTH (OW),
        .P_REQ_NUM       (NREQ),
        .P_INIT_ENTRIES  (NINIT)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_req_valid       (i_req_valid),
        .o_req_ready       (o_req_ready),
        .i_req_dest_mac    (i_req_dest_mac),
        .i_req_outport     (i_req_outport),
        .i_req_flag        (i_req_flag),
        .o_update_dest_mac (o_update_dest_mac),
        .o_update_outport  (o_update_outport),
        .o_update_flag     (o_update_flag),
        .o_update_valid    (o_update_valid),
        .i_update_ready    (i_update_ready),
        .o_grant_id        (o_grant_id),
        .o_init_done       (o_init_done),
        .o_state           (o_state)
    );

    assign out_word = {o_grant_id, o_update_dest_mac, o_update_outport, o_update_flag};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        tb_init_cnt  = 0;
        tb_init_done = 1'b0;
        prev_stall   = 1'b0;
        exp_q.delete();
        for (int k = 0; k < NREQ; k++) src_q[k].delete();
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NREQ; k++) begin
            if (src_q[k].size() > 0) begin
                i_req_valid[k]            = 1'b1;
                i_req_dest_mac[k*48 +: 48] = src_q[k][0].mac;
                i_req_outport[k*OW +: OW]  = src_q[k][0].outport;
                i_req_flag[k]             = src_q[k][0].flag;
            end else begin
                i_req_valid[k] = 1'b0;
            end
        end
        i_update_ready = upd_ready;
    endtask

    task automatic send(input int k, input logic [47:0] mac, input logic [OW-1:0] port,
                        input logic flag);
        entry_t e;
        e.mac     = mac;
        e.outport = port;
        e.flag    = flag;
        src_q[k].push_back(e);
        exp_q.push_back({IW'(k), e});
    endtask

    // One clock: sample and score at negedge, retire accepted source entries after posedge.
    task automatic step();
        logic [NREQ-1:0] hs;
        logic [EW-1:0]   exp_word;
        @(negedge clk);
        chk("init_done", o_init_done, tb_init_done);
        chk("state", o_state, tb_init_done);
        chk("ready_onehot", $countones(o_req_ready) <= 1, 1);
        if (!tb_init_done) chk("init_stall", o_req_ready[2:1], 0);
        if (prev_stall) chk("hold_payload", {o_update_valid, out_word}, {1'b1, prev_out});
        last_ready = o_req_ready;
        if (o_update_valid && i_update_ready) begin
            chk("exp_q_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                exp_word = exp_q.pop_front();
                chk("out_entry", out_word, exp_word);
                if (!tb_init_done && exp_word[EW-1 -: IW] == '0) begin
                    tb_init_cnt++;
                    if (tb_init_cnt == NINIT) tb_init_done = 1'b1;
                end
            end
        end
        prev_stall = o_update_valid && !i_update_ready;
        prev_out   = out_word;
        hs         = i_req_valid & o_req_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            if (hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        end
        drive_inputs();
    endtask

    task automatic drain(input int max_steps);
        int n = 0;
        while (exp_q.size() > 0 && n < max_steps) begin
            step();
            n++;
        end
        chk("drain_done", exp_q.size(), 0);
    endtask

    task automatic init_stream(input logic [47:0] base, input logic [47:0] side_mac);
        for (int i = 1; i <= NINIT; i++) send(0, base + 48'(i), OW'(i), 1'(i));
        send(1, side_mac, 4'h5, FLAG_UNLOCAL);
        drive_inputs();
    endtask

    initial begin
        i_req_valid    = '0;
        i_req_dest_mac = '0;
        i_req_outport  = '0;
        i_req_flag     = '0;
        upd_ready      = 1'b1;
        last_ready     = '0;
        prev_out       = '0;
        reset_model();

        // Reset values, with req0 already presenting data.
        init_stream(48'h0, 48'hAA);
        #12;
        chk("rst_valid", o_update_valid, 0);
        chk("rst_ready", o_req_ready, 0);
        chk("rst_init_done", o_init_done, 0);
        chk("rst_grant_id", o_grant_id, 0);
        chk("rst_mac", o_update_dest_mac, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // INIT fill at 1/clk, req1 held off until init completes.
        repeat (17) step();
        chk("init_fill_rate", exp_q.size(), 1);
        drain(10);

        // Lone req2 twice: moves ptr 2 -> 0, then grants req2 from ptr 0.
        send(2, 48'h201, 4'h2, FLAG_LOCAL);
        drive_inputs();
        drain(10);
        send(2, 48'h202, 4'h3, FLAG_UNLOCAL);
        drive_inputs();
        drain(10);

        // All three continuously valid from ptr 0.
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < NREQ; k++)
                send(k, 48'h3000 + 48'(r*16 + k), OW'(r + k), 1'(r));
        drive_inputs();
        repeat (13) step();
        chk("rr_throughput", exp_q.size(), 0);

        // Output stall with 0x55 in the slot.
        send(0, 48'h55, 4'h1, FLAG_LOCAL);
        drive_inputs();
        step();
        upd_ready = 1'b0;
        send(1, 48'h66, 4'h6, FLAG_UNLOCAL);
        send(2, 48'h77, 4'h7, FLAG_LOCAL);
        drive_inputs();
        repeat (5) begin
            step();
            chk("stall_no_ready", last_ready, 0);
        end
        chk("stall_payload_mac", o_update_dest_mac, 48'h55);
        upd_ready = 1'b1;
        drive_inputs();
        step();
        chk("release_grant", last_ready, 3'b010);
        drain(10);

        // Single requester under random output backpressure.
        for (int i = 0; i < 8; i++) send(1, 48'h900 + 48'(i), OW'(i), 1'(i));
        drive_inputs();
        for (int n = 0; n < 80 && exp_q.size() > 0; n++) begin
            upd_ready = 1'($urandom_range(0, 1));
            drive_inputs();
            step();
        end
        upd_ready = 1'b1;
        drive_inputs();
        drain(10);

        // Reset out of RUN, then reset again mid-INIT with 7 writes done.
        rst_n = 1'b0;
        #1;
        chk("rst_run_init_done", o_init_done, 0);
        chk("rst_run_state", o_state, ST_INIT);
        reset_model();
        for (int i = 1; i <= 20; i++) send(0, 48'h7000 + 48'(i), OW'(i), 1'(i));
        drive_inputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) step();
        chk("mid_init_cnt", tb_init_cnt, 7);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", o_update_valid, 0);
        chk("mid_rst_mac", o_update_dest_mac, 0);
        chk("mid_rst_ready", o_req_ready, 0);
        chk("mid_rst_init_done", o_init_done, 0);
        reset_model();
        init_stream(48'h8000, 48'hBB);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (17) step();
        chk("reinit_fill", exp_q.size(), 1);
        drain(10);

        chk("final_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
